blink_word_loader: RTL and testbench
====================================

# blink_word_loader

Bus-side front end for the Blink_128_256 tweakable block cipher. Assembles the 1280-bit round-key vector, 256-bit tweak and 128-bit data block from a 32-bit valid/ready word stream and holds them stable on the cipher-core inputs for a fixed latency. Captures the core's 128-bit result and returns it as four 32-bit words on an output valid/ready stream. Sits directly upstream and downstream of the cipher core: it drives K0/T/P/enc and consumes C.

## Interface
- `N`, 128: block width in bits
- `TWEAK_LEN`, 256: tweak width in bits
- `ROUND`, 20: cipher rounds; key width `KEY_LEN = N*ROUND/2` = 1280
- `W`, 32: bus word width; `N`, `TWEAK_LEN` and `KEY_LEN` are multiples of `W`
- `CORE_LAT`, 20: cycles from stable core inputs to valid `core_c`; must be at least 1

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  input word accepted when `s_valid & s_ready`
- `s_sel`  in  2  target: 00 key, 01 tweak, 10 data-encrypt, 11 data-decrypt
- `s_data`  in  W  input word
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  output word consumed when `m_valid & m_ready`
- `m_data`  out  W  output word
- `m_last`  out  1  high on the 4th output word
- `err`  out  1  one-cycle pulse: data word dropped because the key is incomplete
- `core_enc`  out  1  to core `enc`
- `core_k0`  out  KEY_LEN  to core `K0`
- `core_t`  out  TWEAK_LEN  to core `T`
- `core_p`  out  N  to core `P`
- `core_c`  in  N  from core `C`

## Operation
- FSM states: IDLE, WAIT, SEND. Reset enters IDLE.
- Reset values: every register is 0, including key, tweak, data, output and indices. `key_full` is 0. `m_valid`, `m_last`, `err` and all `core_*` outputs are 0. `s_ready` is 1, because it is decoded from IDLE.
- `s_ready` is 1 in IDLE only.
- Key write (sel 00): word goes to bits `[W*ki +: W]`. Index `ki` counts 0..39 and then wraps to 0. Writing word 39 sets `key_full`. Rewriting the key later overwrites words in place and leaves `key_full` set.
- Tweak write (sel 01): word goes to `[W*ti +: W]`. Index `ti` counts 0..7 and wraps. The tweak persists across operations.
- Data write (sel 1x):
  - If `key_full` = 0, the word is accepted and dropped, `err` pulses, and `di` resets to 0.
  - Otherwise the word goes to `[W*di +: W]` and `di` counts 0..3. `core_enc` takes the value of `~s_sel[0]` on every data write.
  - On word 3, `di` returns to 0, the down-counter loads `CORE_LAT`, and the FSM moves IDLE→WAIT.
- WAIT: the counter decrements each cycle. When it reaches 1, `core_c` is captured into the output register on that edge and the FSM moves to SEND.
- SEND:
  - `m_valid` = 1. `m_data` = `out[W*oi +: W]`, least significant word first. `m_last` = (`oi` == 3).
  - `m_data` is held stable until the handshake completes.
  - Accepting the last word moves SEND→IDLE and resets `oi` to 0.
- Core inputs are registered. They change only on accepted writes in IDLE, so they are stable throughout WAIT.

## Timing
- Data word 3 is accepted at edge E0. `core_c` is sampled at edge E0+CORE_LAT, and `m_valid` is high from the cycle after that edge.
- If `m_ready` is held high, the four output words take 4 cycles. `s_ready` returns high in the cycle after the last output handshake.
- Total issue-to-reissue time is CORE_LAT+5 cycles, with a stall-free sink.
- `m_ready` low holds the current word. `m_valid` never drops until its handshake completes.
- Key-index wrap: a 41st key word lands in word 0.
- Asserting `rst` mid-WAIT or mid-SEND aborts the operation immediately and clears all state. No partial output is emitted.
- Because `s_ready` is 0 outside IDLE, writes are never simultaneous with an output transfer.

## Configuration
- `BLINK_LOADER_KEY_ZEROIZE_EN`
  - Defined: accepting the last output word also clears the key register, `ki` and `key_full` in the same edge. The next operation requires a full key reload.
  - Undefined: the key persists until it is overwritten or reset.

## Structure
- Package `blink_pkg` holds:
  - `N`, `TWEAK_LEN`, `ROUND`, `KEY_LEN`, `W`
  - `s_sel` encodings: `SEL_KEY`, `SEL_TWEAK`, `SEL_ENC`, `SEL_DEC`
  - the FSM state enum
- One sub-module, `blink_out_serializer`: a 128-bit capture register plus a 2-bit word index, with `m_valid`/`m_ready`/`m_last` logic. It has a load strobe from the FSM and returns a done pulse.

## Test plan
- Reset, then 40 key words `32'h0000_0000+i`, 8 tweak words, and 4 encrypt words; core model returns `P^128'hA5…A5` after exactly 20 cycles → 4 output words equal to the model, LSW first, `m_last` only on word 4, and `core_enc`=1.
- Data word before any key load → `err` pulses for exactly 1 cycle, no `m_valid`, `key_full`=0, and `s_ready` stays 1.
- Decrypt (sel 11) with `m_ready` toggled 1,0,0,1,… → `core_enc`=0, `m_data` stable while stalled, and exactly 4 transfers.
- 41 key words, with word 40 = `32'hDEAD_BEEF` → `core_k0[31:0]`=`32'hDEAD_BEEF` and the other words unchanged.
- `rst` asserted at WAIT counter = 10 → all outputs 0 immediately; after release, `s_ready`=1, `key_full`=0, and no output words.
- Back-to-back operations with the zeroize macro defined → the second data word 3 is dropped with `err`. Without the macro, the second result is returned.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared widths, select encodings and FSM states for the Blink_128_256 word loader.
package blink_pkg;

   localparam int N         = 128;
   localparam int TWEAK_LEN = 256;
   localparam int ROUND     = 20;
   localparam int KEY_LEN   = N * ROUND / 2;
   localparam int W         = 32;

   localparam int KEY_WORDS   = KEY_LEN / W;
   localparam int TWEAK_WORDS = TWEAK_LEN / W;
   localparam int DATA_WORDS  = N / W;

   localparam int KI_W = $clog2(KEY_WORDS);
   localparam int TI_W = $clog2(TWEAK_WORDS);
   localparam int DI_W = $clog2(DATA_WORDS);

   localparam logic [KI_W-1:0] KI_LAST = KI_W'(KEY_WORDS - 1);
   localparam logic [TI_W-1:0] TI_LAST = TI_W'(TWEAK_WORDS - 1);
   localparam logic [DI_W-1:0] DI_LAST = DI_W'(DATA_WORDS - 1);

   typedef logic [1:0] sel_t;
   localparam sel_t SEL_KEY   = 2'b00;
   localparam sel_t SEL_TWEAK = 2'b01;
   localparam sel_t SEL_ENC   = 2'b10;
   localparam sel_t SEL_DEC   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage

// File: rtl/blink_out_serializer.sv
// Captures the 128-bit core result and streams it out as four 32-bit words, LSW first.
module blink_out_serializer
   import blink_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [N-1:0]  cap_i,
   output logic          m_valid_o,
   input  logic          m_ready_i,
   output logic [W-1:0]  m_data_o,
   output logic          m_last_o,
   output logic          done_o
);

   logic [N-1:0]    out_q, out_d;
   logic [DI_W-1:0] oi_q, oi_d;
   logic            valid_q, valid_d;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
      out_d   = out_q;
      oi_d    = oi_q;
      valid_d = valid_q;
      done_o  = 1'b0;
      if (load_i) begin
         out_d   = cap_i;
         oi_d    = '0;
         valid_d = 1'b1;
      end else if (valid_q && m_ready_i) begin
         if (oi_q == DI_LAST) begin
            valid_d = 1'b0;
            oi_d    = '0;
            done_o  = 1'b1;
         end else begin
            oi_d = oi_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         oi_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         oi_q    <= oi_d;
         valid_q <= valid_d;
      end
   end

   assign m_valid_o = valid_q;
   assign m_data_o  = out_q[W*oi_q +: W];
   assign m_last_o  = valid_q && (oi_q == DI_LAST);

endmodule

// File: rtl/blink_word_loader.sv
// Word-stream front end for the Blink_128_256 core: loads key/tweak/data, waits CORE_LAT, returns C.
// Optional BLINK_LOADER_KEY_ZEROIZE_EN: wipe the key when the last output word is accepted.
module blink_word_loader
   import blink_pkg::*;
#(
   parameter int CORE_LAT = 20
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [1:0]            s_sel,
   input  logic [W-1:0]          s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [W-1:0]          m_data,
   output logic                  m_last,
   output logic                  err,
   output logic                  core_enc,
   output logic [KEY_LEN-1:0]    core_k0,
   output logic [TWEAK_LEN-1:0]  core_t,
   output logic [N-1:0]          core_p,
   input  logic [N-1:0]          core_c
);

   localparam int CNT_W = $clog2(CORE_LAT + 1);

   state_t               state_q, state_d;
   logic [KEY_LEN-1:0]   key_q, key_d;
   logic [TWEAK_LEN-1:0] tweak_q, tweak_d;
   logic [N-1:0]         data_q, data_d;
   logic                 enc_q, enc_d;
   logic [KI_W-1:0]      ki_q, ki_d;
   logic [TI_W-1:0]      ti_q, ti_d;
   logic [DI_W-1:0]      di_q, di_d;
   logic                 key_full_q, key_full_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 load;
   logic                 done;

   assign s_ready = (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      tweak_d    = tweak_q;
      data_d     = data_q;
      enc_d      = enc_q;
      ki_d       = ki_q;
      ti_d       = ti_q;
      di_d       = di_q;
      key_full_d = key_full_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      load       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s_valid) begin
               unique case (s_sel)
                  SEL_KEY: begin
                     key_d[W*ki_q +: W] = s_data;
                     if (ki_q == KI_LAST) begin
                        ki_d       = '0;
                        key_full_d = 1'b1;
                     end else begin
                        ki_d = ki_q + 1'b1;
                     end
                  end
                  SEL_TWEAK: begin
                     tweak_d[W*ti_q +: W] = s_data;
                     ti_d = (ti_q == TI_LAST) ? '0 : ti_q + 1'b1;
                  end
                  default: begin
                     // Without a complete key the word is swallowed and the block restarts.
                     if (!key_full_q) begin
                        err_d = 1'b1;
                        di_d  = '0;
                     end else begin
                        data_d[W*di_q +: W] = s_data;
                        enc_d = ~s_sel[0];
                        if (di_q == DI_LAST) begin
                           di_d    = '0;
                           cnt_d   = CNT_W'(CORE_LAT);
                           state_d = WAIT;
                        end else begin
                           di_d = di_q + 1'b1;
                        end
                     end
                  end
               endcase
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (done) begin
               state_d = IDLE;
`ifdef BLINK_LOADER_KEY_ZEROIZE_EN
               key_d      = '0;
               ki_d       = '0;
               key_full_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the wide key/tweak/data registers are reset too, so the core never sees stale material after rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         key_q      <= '0;
         tweak_q    <= '0;
         data_q     <= '0;
         enc_q      <= 1'b0;
         ki_q       <= '0;
         ti_q       <= '0;
         di_q       <= '0;
         key_full_q <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         tweak_q    <= tweak_d;
         data_q     <= data_d;
         enc_q      <= enc_d;
         ki_q       <= ki_d;
         ti_q       <= ti_d;
         di_q       <= di_d;
         key_full_q <= key_full_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   blink_out_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .cap_i     (core_c),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .done_o    (done)
   );

   assign err      = err_q;
   assign core_enc = enc_q;
   assign core_k0  = key_q;
   assign core_t   = tweak_q;
   assign core_p   = data_q;

endmodule

// File: tb/tb_blink_word_loader.sv
// Scoreboard bench for blink_word_loader with a latency-accurate stand-in cipher core.
module tb_blink_word_loader;
   import blink_pkg::*;

   localparam int CORE_LAT = 20;
   localparam logic [N-1:0] MASK = {16{8'hA5}};

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic [1:0]           s_sel = 2'b00;
   logic [W-1:0]         s_data = '0;
   logic                 m_valid;
   logic                 m_ready = 1'b1;
   logic [W-1:0]         m_data;
   logic                 m_last;
   logic                 err;
   logic                 core_enc;
   logic [KEY_LEN-1:0]   core_k0;
   logic [TWEAK_LEN-1:0] core_t;
   logic [N-1:0]         core_p;
   logic [N-1:0]         core_c;

   always #5 clk = ~clk;

   blink_word_loader #(.CORE_LAT(CORE_LAT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .err(err), .core_enc(core_enc), .core_k0(core_k0), .core_t(core_t),
      .core_p(core_p), .core_c(core_c)
   );

   // Stand-in core: C = P ^ A5.. only once its inputs have been stable CORE_LAT cycles, garbage before.
   logic [N-1:0]         snap_p = '0;
   logic                 snap_enc = 1'b0;
   logic [KEY_LEN-1:0]   snap_k = '0;
   logic [TWEAK_LEN-1:0] snap_t = '0;
   int                   age = 0;
   always @(negedge clk) begin
      if ({core_enc, core_k0, core_t, core_p} != {snap_enc, snap_k, snap_t, snap_p}) begin
         snap_enc <= core_enc; snap_k <= core_k0; snap_t <= core_t; snap_p <= core_p;
         age <= 1;
      end else if (age < 1000) begin
         age <= age + 1;
      end
   end
   assign core_c = (age >= CORE_LAT) ? (snap_p ^ MASK) : ~(snap_p ^ MASK);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain arrays of words and write indices.
   logic [W-1:0] m_key[KEY_WORDS];
   logic [W-1:0] m_tw[TWEAK_WORDS];
   logic [W-1:0] m_dat[DATA_WORDS];
   int m_ki, m_ti, m_di;
   bit m_kfull, m_enc;

   typedef struct { logic [W-1:0] data; bit last; } exp_t;
   exp_t exp_q[$];
   int   issue_q[$];

   int checks = 0, errors = 0;
   int exp_err = 0, seen_err = 0, exp_xfers = 0, seen_xfers = 0;
   int rdy_mode = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < KEY_WORDS; i++) m_key[i] = '0;
      for (int i = 0; i < TWEAK_WORDS; i++) m_tw[i] = '0;
      for (int i = 0; i < DATA_WORDS; i++) m_dat[i] = '0;
      m_ki = 0; m_ti = 0; m_di = 0; m_kfull = 0; m_enc = 0;
   endtask

   function automatic logic [KEY_LEN-1:0] key_vec();
      logic [KEY_LEN-1:0] v;
      for (int i = 0; i < KEY_WORDS; i++) v[W*i +: W] = m_key[i];
      return v;
   endfunction

   function automatic logic [TWEAK_LEN-1:0] tw_vec();
      logic [TWEAK_LEN-1:0] v;
      for (int i = 0; i < TWEAK_WORDS; i++) v[W*i +: W] = m_tw[i];
      return v;
   endfunction

   function automatic logic [N-1:0] dat_vec();
      logic [N-1:0] v;
      for (int i = 0; i < DATA_WORDS; i++) v[W*i +: W] = m_dat[i];
      return v;
   endfunction

   task automatic check_key(input string name);
      logic [KEY_LEN-1:0] k;
      k = key_vec();
      for (int c = 0; c < KEY_LEN / 256; c++)
         check($sformatf("%s_chunk%0d", name, c), core_k0[256*c +: 256], k[256*c +: 256]);
   endtask

   // Called #1 after a rising edge; returns #1 after the handshake edge.
   task automatic send(input logic [1:0] sel, input logic [W-1:0] data);
      int  n;
      bit  issued;
      logic [N-1:0] res;
      n = 0; issued = 0;
      s_valid = 1'b1; s_sel = sel; s_data = data;
      while (!s_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: s_ready got 0 required 1");
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (sel == SEL_KEY) begin
         m_key[m_ki] = data;
         if (m_ki == KEY_WORDS - 1) begin m_ki = 0; m_kfull = 1; end else m_ki++;
      end else if (sel == SEL_TWEAK) begin
         m_tw[m_ti] = data;
         m_ti = (m_ti + 1) % TWEAK_WORDS;
      end else if (!m_kfull) begin
         exp_err++;
         m_di = 0;
      end else begin
         m_dat[m_di] = data;
         m_enc = ~sel[0];
         if (m_di == DATA_WORDS - 1) begin
            res = dat_vec() ^ MASK;
            for (int i = 0; i < DATA_WORDS; i++)
               exp_q.push_back('{data: res[W*i +: W], last: (i == DATA_WORDS - 1)});
            exp_xfers += DATA_WORDS;
            m_di = 0;
            issued = 1;
         end else begin
            m_di++;
         end
      end
      #1;
      s_valid = 1'b0;
      if (issued) begin
         issue_q.push_back(cyc);
         check("core_p", 256'(core_p), 256'(dat_vec()));
         check("core_enc", 256'(core_enc), 256'(m_enc));
         check("core_t", core_t, tw_vec());
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(s_ready && exp_q.size() == 0) && n < budget) begin
         @(posedge clk); #1; n++;
      end
      check("idle_timeout", 256'(n < budget), 256'(1));
   endtask

   task automatic send_op(input bit dec);
      for (int i = 0; i < DATA_WORDS; i++) send(dec ? SEL_DEC : SEL_ENC, $urandom());
   endtask

   task automatic load_key_random();
      for (int i = 0; i < KEY_WORDS; i++) send(SEL_KEY, $urandom());
   endtask

   // Sink: always ready, fixed 1,0,0,1 pattern, or random.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin m_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      bit stall_pend, prev_valid, last_pend;
      logic [W-1:0] held;
      exp_t e;
      int ic;
      stall_pend = 0; prev_valid = 0; last_pend = 0; held = '0;
      forever begin
         @(negedge clk);
         if (err) seen_err++;
         if (last_pend) begin
            check("s_ready_after_last", 256'(s_ready), 256'(1));
            last_pend = 0;
         end
         if (stall_pend) begin
            check("stall_valid_held", 256'(m_valid), 256'(1));
            check("stall_data_held", 256'(m_data), 256'(held));
         end
         if (m_valid && !prev_valid && issue_q.size() > 0) begin
            ic = issue_q.pop_front();
            check("valid_latency", 256'(cyc), 256'(ic + CORE_LAT));
         end
         if (m_valid && m_ready) begin
            seen_xfers++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 256'(m_data), 256'(0));
               errors += (checks > 0 && m_data == '0) ? 1 : 0;
            end else begin
               e = exp_q.pop_front();
               check("m_data", 256'(m_data), 256'(e.data));
               check("m_last", 256'(m_last), 256'(e.last));
               if (e.last) begin
                  last_pend = 1;
`ifdef BLINK_LOADER_KEY_ZEROIZE_EN
                  for (int i = 0; i < KEY_WORDS; i++) m_key[i] = '0;
                  m_ki = 0; m_kfull = 0;
`endif
               end
            end
         end
         stall_pend = m_valid && !m_ready;
         held = m_data;
         prev_valid = m_valid;
      end
   end

   initial begin
      int xf;
      model_reset();
      #2 rst = 1'b0;
      #1;
      check("rst_s_ready", 256'(s_ready), 256'(1));
      check("rst_m_valid", 256'(m_valid), 256'(0));
      check("rst_m_last", 256'(m_last), 256'(0));
      check("rst_err", 256'(err), 256'(0));
      check("rst_core_enc", 256'(core_enc), 256'(0));
      check("rst_core_p", 256'(core_p), 256'(0));
      check("rst_core_t", core_t, 256'(0));
      check_key("rst_core_k0");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Data word with no key loaded.
      send(SEL_ENC, $urandom());
      repeat (3) @(posedge clk); #1;
      check("nokey_err_cycles", 256'(seen_err), 256'(exp_err));
      check("nokey_s_ready", 256'(s_ready), 256'(1));
      check("nokey_no_output", 256'(seen_xfers), 256'(0));

      // Directed encrypt with counting key.
      rdy_mode = 0;
      for (int i = 0; i < KEY_WORDS; i++) send(SEL_KEY, W'(i));
      check_key("key_load");
      for (int i = 0; i < TWEAK_WORDS; i++) send(SEL_TWEAK, $urandom());
      send_op(1'b0);
      check("enc_flag", 256'(core_enc), 256'(1));
      wait_idle(200);
      check("enc_xfers", 256'(seen_xfers), 256'(4));

      // Decrypt against a stalling sink.
      if (!m_kfull) load_key_random();
      rdy_mode = 1;
      send_op(1'b1);
      check("dec_flag", 256'(core_enc), 256'(0));
      wait_idle(300);
      check("dec_xfers", 256'(seen_xfers), 256'(exp_xfers));
      rdy_mode = 0;

      // 41 key words: the last wraps onto word 0.
      for (int i = 0; i < KEY_WORDS; i++) send(SEL_KEY, $urandom());
      send(SEL_KEY, 32'hDEAD_BEEF);
      check("key_wrap_word0", 256'(core_k0[31:0]), 256'(32'hDEAD_BEEF));
      check_key("key_wrap");

      // Randomized operations.
      rdy_mode = 2;
      for (int op = 0; op < 6; op++) begin
         if (!m_kfull || ($urandom_range(0, 3) == 0)) load_key_random();
         if ($urandom_range(0, 1) == 1)
            for (int i = 0; i < TWEAK_WORDS; i++) send(SEL_TWEAK, $urandom());
         send_op(1'($urandom_range(0, 1)));
         wait_idle(400);
      end
      rdy_mode = 0;

      // Back-to-back; with zeroize the second block is dropped with err.
      load_key_random();
      send_op(1'b0);
      send_op(1'b0);
      wait_idle(300);
      check("b2b_xfers", 256'(seen_xfers), 256'(exp_xfers));
      check("b2b_err", 256'(seen_err), 256'(exp_err));

      // Reset in the middle of WAIT (counter = 10).
      load_key_random();
      send_op(1'b0);
      repeat (10) @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_m_valid", 256'(m_valid), 256'(0));
      check("midrst_err", 256'(err), 256'(0));
      check("midrst_core_p", 256'(core_p), 256'(0));
      check("midrst_core_t", core_t, 256'(0));
      check("midrst_core_enc", 256'(core_enc), 256'(0));
      exp_q.delete();
      issue_q.delete();
      exp_xfers -= DATA_WORDS;
      model_reset();
      check_key("midrst_core_k0");
      xf = seen_xfers;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (30) @(posedge clk); #1;
      check("midrst_no_output", 256'(seen_xfers), 256'(xf));
      check("midrst_s_ready", 256'(s_ready), 256'(1));
      send(SEL_ENC, $urandom());
      repeat (3) @(posedge clk); #1;
      check("midrst_keyfull_cleared", 256'(seen_err), 256'(exp_err));

      check("final_queue_empty", 256'(exp_q.size()), 256'(0));
      check("final_xfers", 256'(seen_xfers), 256'(exp_xfers));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
